dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
- Parametrised, byte-addressable RV32I data memory with a valid/ready request/response handshake.
- Supports sub-word loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) with little-endian byte lanes and sign/zero extension.
- Response latency is configurable; illegal and out-of-range accesses are reported.
- Sits between the core's MEM stage and the data storage, replacing the word-only combinational memory.

Parameters:
- XLEN, 32, data width in bits; fixed multiple of 8.
- MEM_BYTES, 4096, memory size in bytes.
- ADDR_W, 32, request address width.
- LATENCY, 1, cycles from request accept to o_rsp_valid; must be at least 1.

Ports:
- i_clock  in  1  clock.
- i_reset_n  in  1  asynchronous reset, active-low.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  controller can accept a request.
- i_req_we  in  1  1 = store, 0 = load.
- i_req_addr  in  ADDR_W  byte address.
- i_req_funct3  in  3  RV32I load/store funct3 (access size and sign).
- i_req_wdata  in  XLEN  store data; low bytes are used for SB/SH.
- o_rsp_valid  out  1  response present.
- i_rsp_ready  in  1  consumer accepts the response.
- o_rsp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- o_rsp_err  out  1  access faulted; no memory update occurred.

Behaviour:
- Clock and reset: single clock i_clock; i_reset_n is asynchronous and active-low.
- Reset values: o_req_ready=0 while reset is asserted, then 1 in IDLE; o_rsp_valid=0; o_rsp_rdata=0; o_rsp_err=0; FSM=IDLE; wait counter=0.
- Memory contents are not reset.
- FSM states:
  - IDLE (o_req_ready=1).
  - WAIT: counts LATENCY-1 cycles; skipped when LATENCY=1.
  - RESP (o_rsp_valid=1).
- Transitions:
  - IDLE to WAIT/RESP when i_req_valid && o_req_ready.
  - WAIT to RESP when the counter reaches LATENCY-1.
  - RESP to IDLE when i_rsp_ready.
  - o_req_ready=0 outside IDLE, so there is at most one outstanding request.
- Accept edge:
  - Request fields are decoded.
  - Stores are committed to the array on this same edge.
  - Load data is read and extended into the response register on this same edge.
  - o_rsp_rdata and o_rsp_err are held stable throughout WAIT and RESP.
- funct3 decode:
  - 000 byte signed (LB/SB).
  - 001 half signed (LH/SH).
  - 010 word (LW/SW).
  - 100 byte unsigned (LBU).
  - 101 half unsigned (LHU).
  - For stores, only 000/001/010 are legal; anything else is illegal and sets err.
- Byte lanes:
  - Byte n of the access maps to address addr+n (little-endian).
  - Loads place the byte/half in the low bits, then sign-extend (000/001) or zero-extend (100/101) to XLEN.
- Range check: err=1 if addr+size-1 >= MEM_BYTES, computed without truncation, so addresses near 2^ADDR_W-1 do not wrap to in-range.
- Errors: no array write, rdata=0, err=1, same latency as a normal access.
- Store response: rdata=0, err=0.
- Response backpressure: o_rsp_valid stays high and data stays stable until i_rsp_ready. i_rsp_ready is ignored outside RESP.
- Simultaneous events: i_req_valid asserted while in RESP is not accepted until the cycle after the handshake completes (no same-cycle turnaround).
- Reset mid-operation:
  - FSM returns to IDLE and any pending response is discarded.
  - A store already committed at its accept edge remains in memory.

Optional Feature:
- Macro: DMEM_MISALIGN_ERR_EN.
- Defined: a halfword access with addr[0]!=0, or a word access with addr[1:0]!=0, returns err=1, rdata=0, and no write.
- Undefined: misaligned accesses are performed byte-wise at addr..addr+size-1 (range check still applies), with no error.

Test Plan:
- Store then load, LATENCY=1: SW 0xDEADBEEF @0x10 (err=0, rdata=0); then LW @0x10 -> rdata=0xDEADBEEF 1 cycle after accept. LB @0x13 -> 0xFFFFFFDE. LBU @0x13 -> 0x000000DE. LH @0x10 -> 0xFFFFBEEF. LHU @0x12 -> 0x0000DEAD.
- Sub-word store: SW 0x11223344 @0x20; SB wdata=0xAB @0x21; SH wdata=0xCDEF @0x22; LW @0x20 -> 0xCDEFAB44.
- Errors: LW @MEM_BYTES-2 -> err=1, rdata=0. SW funct3=011 @0x0 -> err=1; a following LW @0x0 is unchanged.
- Latency/backpressure, LATENCY=3: accept at cycle t gives o_rsp_valid at t+3. Hold i_rsp_ready=0 for 4 cycles -> rdata stable, o_req_ready=0 throughout. Ready=1 returns to IDLE next cycle.
- Reset mid-op, LATENCY=4: accept SW 0x55 @0x30, then assert i_reset_n=0 in WAIT -> o_rsp_valid=0 immediately. After reset release, LW @0x30 -> 0x00000055.
- Misalignment: LW @0x11 after SW 0xDEADBEEF @0x10 and SW 0x00000077 @0x14. With DMEM_MISALIGN_ERR_EN: err=1. Without it: rdata=0x77DEADBE.

Source files
------------

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-addressable RV32I data memory with valid/ready request and
// response handshakes, sub-word loads/stores, configurable response latency
// and range/illegal-access error reporting.
// Optional: define DMEM_MISALIGN_ERR_EN to fault misaligned half/word
// accesses instead of performing them byte-wise.
module dmem_ctrl #(
  parameter int XLEN      = 32,
  parameter int MEM_BYTES = 4096,
  parameter int ADDR_W    = 32,
  parameter int LATENCY   = 1
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [2:0]        i_req_funct3,
  input  logic [XLEN-1:0]   i_req_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [XLEN-1:0]   o_rsp_rdata,
  output logic              o_rsp_err
);

  localparam int IDX_W = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) + 1 : 1;
  localparam logic [ADDR_W:0]  MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [7:0]        mem [MEM_BYTES];

  logic              accept;
  logic [1:0]        size_m1;
  logic              legal;
  logic              unsigned_ld;
  logic              out_of_range;
  logic              misalign;
  logic              acc_err;
  logic [ADDR_W:0]   end_addr;
  logic [IDX_W-1:0]  lane_idx [4];
  logic [7:0]        rd_byte [4];
  logic [XLEN-1:0]   ld_data;
  logic [XLEN-1:0]   rsp_rdata_q;
  logic              rsp_err_q;

  assign o_req_ready = (state_q == IDLE) && i_reset_n;
  assign o_rsp_valid = (state_q == RESP);
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_err   = rsp_err_q;
  assign accept      = i_req_valid && o_req_ready;

  // Decode funct3 into size/sign/legality and check the access against the array bounds
  always_comb begin
    size_m1     = 2'd0;
    legal       = 1'b0;
    unsigned_ld = i_req_funct3[2];
    case (i_req_funct3)
      3'b000: begin size_m1 = 2'd0; legal = 1'b1;       end
      3'b001: begin size_m1 = 2'd1; legal = 1'b1;       end
      3'b010: begin size_m1 = 2'd3; legal = 1'b1;       end
      3'b100: begin size_m1 = 2'd0; legal = !i_req_we;  end
      3'b101: begin size_m1 = 2'd1; legal = !i_req_we;  end
      default: begin size_m1 = 2'd0; legal = 1'b0;      end
    endcase
    // One extra bit keeps addresses near the top of the space from wrapping into range
    end_addr     = {1'b0, i_req_addr} + (ADDR_W+1)'(size_m1);
    out_of_range = (end_addr >= MEM_LIMIT);
`ifdef DMEM_MISALIGN_ERR_EN
    misalign = ((size_m1 == 2'd1) && i_req_addr[0]) ||
               ((size_m1 == 2'd3) && (i_req_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    acc_err = !legal || out_of_range || misalign;
  end

  // Gather the four little-endian byte lanes and extend the load result to XLEN
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      lane_idx[n] = i_req_addr[IDX_W-1:0] + IDX_W'(n);
      rd_byte[n]  = mem[lane_idx[n]];
    end
    ld_data = '0;
    case (size_m1)
      2'd0: ld_data = unsigned_ld ? XLEN'(rd_byte[0])
                                  : XLEN'($signed(rd_byte[0]));
      2'd1: ld_data = unsigned_ld ? XLEN'({rd_byte[1], rd_byte[0]})
                                  : XLEN'($signed({rd_byte[1], rd_byte[0]}));
      default: ld_data = XLEN'({rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]});
    endcase
  end

  // Commit stores on the accept edge; the array itself is never reset
  always_ff @(posedge i_clock) begin
    if (accept && i_req_we && !acc_err) begin
      for (int n = 0; n < 4; n++) begin
        if (n <= int'(size_m1)) begin
          mem[lane_idx[n]] <= i_req_wdata[8*n +: 8];
        end
      end
    end
  end

  // Capture the response on the accept edge and hold it through WAIT and RESP
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (accept) begin
      rsp_err_q   <= acc_err;
      rsp_rdata_q <= (acc_err || i_req_we) ? '0 : ld_data;
    end
  end

  // State and latency counter registers
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: accept in IDLE, burn LATENCY-1 cycles in WAIT, hold RESP until taken
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (i_rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed scoreboard bench for dmem_ctrl, three instances with
// LATENCY 1, 3 and 4. Expected results are queued when a request is driven
// and compared when the matching response appears.
module tb_dmem_ctrl;

  localparam int NDUT = 3;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n     [NDUT];
  logic        req_valid [NDUT];
  logic        req_ready [NDUT];
  logic        req_we    [NDUT];
  logic [31:0] req_addr  [NDUT];
  logic [2:0]  req_f3    [NDUT];
  logic [31:0] req_wdata [NDUT];
  logic        rsp_valid [NDUT];
  logic        rsp_ready [NDUT];
  logic [31:0] rsp_rdata [NDUT];
  logic        rsp_err   [NDUT];

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    dmem_ctrl #(
      .XLEN(32),
      .MEM_BYTES(4096),
      .ADDR_W(32),
      .LATENCY((g == 0) ? 1 : ((g == 1) ? 3 : 4))
    ) u_dut (
      .i_clock(clk),
      .i_reset_n(rst_n[g]),
      .i_req_valid(req_valid[g]),
      .o_req_ready(req_ready[g]),
      .i_req_we(req_we[g]),
      .i_req_addr(req_addr[g]),
      .i_req_funct3(req_f3[g]),
      .i_req_wdata(req_wdata[g]),
      .o_rsp_valid(rsp_valid[g]),
      .i_rsp_ready(rsp_ready[g]),
      .o_rsp_rdata(rsp_rdata[g]),
      .o_rsp_err(rsp_err[g])
    );
  end

  function automatic int latOf(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", name, obs, exp);
    end
  endtask

  // Pop the scoreboard entry, compare it, optionally stall, then complete the handshake
  task automatic collectResponse(input int d, input int hold);
    exp_t e;
    if (sb.size() == 0) begin
      checkOutput("scoreboard empty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    checkOutput({e.name, " rdata"}, rsp_rdata[d], e.rdata);
    checkOutput({e.name, " err"}, 32'(rsp_err[d]), 32'(e.err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkOutput({e.name, " hold valid"}, 32'(rsp_valid[d]), 32'd1);
      checkOutput({e.name, " hold ready"}, 32'(req_ready[d]), 32'd0);
      checkOutput({e.name, " hold rdata"}, rsp_rdata[d], e.rdata);
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    checkOutput({e.name, " done valid"}, 32'(rsp_valid[d]), 32'd0);
    checkOutput({e.name, " done ready"}, 32'(req_ready[d]), 32'd1);
  endtask

  // Drive one request, queue its expected result and check latency and response
  task automatic applyStimulus(input int d, input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input logic exp_err,
                               input string name, input int hold);
    int edges;
    edges = 0;
    while (!req_ready[d] && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    checkOutput({name, " req_ready"}, 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_f3[d]    = f3;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    sb.push_back('{name, exp_rdata, exp_err});
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    req_wdata[d] = 32'h0;
    edges = 1;
    while (!rsp_valid[d] && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    checkOutput({name, " latency"}, 32'(edges), 32'(latOf(d)));
    collectResponse(d, hold);
  endtask

  initial begin
    logic [31:0] mis_rdata;
    logic        mis_err;
`ifdef DMEM_MISALIGN_ERR_EN
    mis_rdata = 32'h0;
    mis_err   = 1'b1;
`else
    mis_rdata = 32'h77DEADBE;
    mis_err   = 1'b0;
`endif
    for (int d = 0; d < NDUT; d++) begin
      rst_n[d]     = 1'b0;
      req_valid[d] = 1'b0;
      req_we[d]    = 1'b0;
      req_addr[d]  = 32'h0;
      req_f3[d]    = 3'b000;
      req_wdata[d] = 32'h0;
      rsp_ready[d] = 1'b0;
    end
    #1;
    checkOutput("reset req_ready", 32'(req_ready[0]), 32'd0);
    checkOutput("reset rsp_valid", 32'(rsp_valid[0]), 32'd0);
    checkOutput("reset rsp_rdata", rsp_rdata[0], 32'h0);
    checkOutput("reset rsp_err", 32'(rsp_err[0]), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) rst_n[d] = 1'b1;
    #1;
    checkOutput("post-reset req_ready", 32'(req_ready[0]), 32'd1);
    @(posedge clk); #1;

    $display("[TB] store/load sequence, LATENCY=1");
    applyStimulus(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "SW @10", 0);
    applyStimulus(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "LW @10", 0);
    applyStimulus(0, 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, "LB @13", 0);
    applyStimulus(0, 1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0, "LBU @13", 0);
    applyStimulus(0, 1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0, "LH @10", 0);
    applyStimulus(0, 1'b0, 3'b101, 32'h12, 32'h0, 32'h0000DEAD, 1'b0, "LHU @12", 0);

    $display("[TB] sub-word stores");
    applyStimulus(0, 1'b1, 3'b010, 32'h20, 32'h11223344, 32'h0, 1'b0, "SW @20", 0);
    applyStimulus(0, 1'b1, 3'b000, 32'h21, 32'hFFFFFFAB, 32'h0, 1'b0, "SB @21", 0);
    applyStimulus(0, 1'b1, 3'b001, 32'h22, 32'hFFFFCDEF, 32'h0, 1'b0, "SH @22", 0);
    applyStimulus(0, 1'b0, 3'b010, 32'h20, 32'h0, 32'hCDEFAB44, 1'b0, "LW @20", 0);

    $display("[TB] range and illegal accesses");
    applyStimulus(0, 1'b1, 3'b010, 32'd4092, 32'h0BADF00D, 32'h0, 1'b0, "SW @top", 0);
    applyStimulus(0, 1'b0, 3'b010, 32'd4092, 32'h0, 32'h0BADF00D, 1'b0, "LW @top", 0);
    applyStimulus(0, 1'b0, 3'b100, 32'd4095, 32'h0, 32'h0000000B, 1'b0, "LBU @last", 0);
    applyStimulus(0, 1'b0, 3'b010, 32'd4094, 32'h0, 32'h0, 1'b1, "LW @4094", 0);
    applyStimulus(0, 1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b1, "LH @wrap", 0);
    applyStimulus(0, 1'b1, 3'b010, 32'h0, 32'h01020304, 32'h0, 1'b0, "SW @0", 0);
    applyStimulus(0, 1'b1, 3'b011, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b1, "SW f3=011", 0);
    applyStimulus(0, 1'b1, 3'b100, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b1, "SW f3=100", 0);
    applyStimulus(0, 1'b0, 3'b110, 32'h0, 32'h0, 32'h0, 1'b1, "LD f3=110", 0);
    applyStimulus(0, 1'b0, 3'b010, 32'h0, 32'h0, 32'h01020304, 1'b0, "LW @0 kept", 0);

    $display("[TB] misaligned word load");
    applyStimulus(0, 1'b1, 3'b010, 32'h14, 32'h00000077, 32'h0, 1'b0, "SW @14", 0);
    applyStimulus(0, 1'b0, 3'b010, 32'h11, 32'h0, mis_rdata, mis_err, "LW @11", 0);

    $display("[TB] latency and backpressure, LATENCY=3");
    applyStimulus(1, 1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0, "L3 SW @40", 0);
    applyStimulus(1, 1'b0, 3'b010, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0, "L3 LW @40", 4);
    applyStimulus(1, 1'b0, 3'b000, 32'h43, 32'h0, 32'hFFFFFFCA, 1'b0, "L3 LB @43", 1);

    $display("[TB] reset during WAIT, LATENCY=4");
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b1;
    req_f3[2]    = 3'b010;
    req_addr[2]  = 32'h30;
    req_wdata[2] = 32'h00000055;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    req_we[2]    = 1'b0;
    checkOutput("L4 wait ready", 32'(req_ready[2]), 32'd0);
    @(posedge clk); #1;
    rst_n[2] = 1'b0;
    #1;
    checkOutput("L4 reset valid", 32'(rsp_valid[2]), 32'd0);
    checkOutput("L4 reset ready", 32'(req_ready[2]), 32'd0);
    @(posedge clk); #1;
    rst_n[2] = 1'b1;
    #1;
    checkOutput("L4 release ready", 32'(req_ready[2]), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("L4 no stale rsp", 32'(rsp_valid[2]), 32'd0);
    applyStimulus(2, 1'b0, 3'b010, 32'h30, 32'h0, 32'h00000055, 1'b0, "L4 LW @30", 0);

    checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
